// File: rtl/qed_inst_dup.sv
// SQED instruction duplicator: forwards eligible originals (x1..x15) to decode,
// queues them, and later replays each as a duplicate remapped onto x16..x31.
module qed_inst_dup #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_i,
    input  logic             inst_vld_i,
    output logic             inst_ready_o,
    input  logic             exec_dup_i,
    input  logic             stall_i,
    output logic [31:0]      inst_o,
    output logic             qed_vld_o,
    output logic             dup_o,
    output logic [PTR_W:0]   fifo_cnt_o,
    output logic             fifo_full_o,
    output logic             fifo_empty_o
);

    localparam logic [31:0]    NOP      = 32'h00000013;
    localparam logic [6:0]     OPC_OP   = 7'b0110011;
    localparam logic [6:0]     OPC_OPI  = 7'b0010011;
    localparam logic [6:0]     OPC_LUI  = 7'b0110111;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [31:0]      inst_q, inst_d;
    logic             qed_vld_q, qed_vld_d;
    logic             dup_q, dup_d;
    logic [PTR_W:0]   bal_q, bal_d;

    logic        is_op, is_opi, is_lui, elig;
    logic        dup_sel, push, pop;
    logic [31:0] head, head_dup;

    // Only base-ISA OP/OP-IMM/LUI touching x1..x15 can be mirrored safely.
    always_comb begin
        is_op  = (inst_i[6:0] == OPC_OP) &&
                 ((inst_i[31:25] == 7'b0000000) || (inst_i[31:25] == 7'b0100000));
        is_opi = (inst_i[6:0] == OPC_OPI);
        is_lui = (inst_i[6:0] == OPC_LUI);
        elig   = (is_op || is_opi || is_lui) &&
                 (inst_i[11:7] != 5'd0) && !inst_i[11] &&
                 (is_lui || !inst_i[19]) &&
                 (!is_op || !inst_i[24]);
    end

    // Queue only holds eligible instructions, so rd is known non-zero here.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        head_dup = head;
        head_dup[11] = 1'b1;
        if ((head[6:0] == OPC_OP || head[6:0] == OPC_OPI) && head[19:15] != 5'd0)
            head_dup[19] = 1'b1;
        if (head[6:0] == OPC_OP && head[24:20] != 5'd0)
            head_dup[24] = 1'b1;
    end

    always_comb begin
        dup_sel      = (cnt_q != '0) && (exec_dup_i || (cnt_q == CNT_FULL));
        inst_ready_o = !stall_i && !dup_sel && inst_vld_i;
        pop          = !stall_i && dup_sel;
        push         = inst_ready_o && elig;

        inst_d    = inst_q;
        qed_vld_d = qed_vld_q;
        dup_d     = dup_q;
        if (!stall_i) begin
            inst_d    = NOP;
            qed_vld_d = 1'b0;
            dup_d     = 1'b0;
            if (dup_sel) begin
                inst_d    = head_dup;
                qed_vld_d = 1'b1;
                dup_d     = 1'b1;
            end else if (inst_ready_o && elig) begin
                inst_d    = inst_i;
                qed_vld_d = 1'b1;
            end
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push)
            cnt_d = cnt_q + (PTR_W+1)'(1);
        else if (pop)
            cnt_d = cnt_q - (PTR_W+1)'(1);

        // Balance of issued originals vs duplicates, derived from the output path.
        bal_d = bal_q;
        if (!stall_i && qed_vld_d && !dup_d)
            bal_d = bal_q + (PTR_W+1)'(1);
        else if (!stall_i && dup_d)
            bal_d = bal_q - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            bal_q     <= '0;
            inst_q    <= NOP;
            qed_vld_q <= 1'b0;
            dup_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            bal_q     <= bal_d;
            inst_q    <= inst_d;
            qed_vld_q <= qed_vld_d;
            dup_q     <= dup_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= inst_i;
    end

    assign inst_o       = inst_q;
    assign qed_vld_o    = qed_vld_q;
    assign dup_o        = dup_q;
    assign fifo_cnt_o   = cnt_q;
    assign fifo_full_o  = (cnt_q == CNT_FULL);
    assign fifo_empty_o = (cnt_q == '0);

    a_balance: assert property (@(posedge clk) disable iff (!rst) bal_q == cnt_q);
    a_cnt_max: assert property (@(posedge clk) disable iff (!rst) cnt_q <= CNT_FULL);

endmodule

// File: tb/tb_qed_inst_dup.sv
// Scoreboard bench for qed_inst_dup: a queue-based reference model predicts each
// registered output and the combinational ready; a monitor pops and compares.
module tb_qed_inst_dup;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_i = '0;
  logic        inst_vld_i = 1'b0;
  logic        inst_ready_o;
  logic        exec_dup_i = 1'b0;
  logic        stall_i = 1'b0;
  logic [31:0] inst_o;
  logic        qed_vld_o;
  logic        dup_o;
  logic [3:0]  fifo_cnt_o;
  logic        fifo_full_o;
  logic        fifo_empty_o;

  qed_inst_dup #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst),
    .inst_i(inst_i), .inst_vld_i(inst_vld_i), .inst_ready_o(inst_ready_o),
    .exec_dup_i(exec_dup_i), .stall_i(stall_i),
    .inst_o(inst_o), .qed_vld_o(qed_vld_o), .dup_o(dup_o),
    .fifo_cnt_o(fifo_cnt_o), .fifo_full_o(fifo_full_o), .fifo_empty_o(fifo_empty_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // expected entry: {inst[31:0], qed_vld, dup, cnt[3:0]}
  logic [37:0] exp_q[$];

  // reference model state
  logic [31:0] mq[$];
  logic [31:0] m_inst = NOP;
  logic        m_vld = 1'b0;
  logic        m_dup = 1'b0;
  logic        last_ready = 1'b0;

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_lo(input int r);
    return (r >= 1) && (r <= 15);
  endfunction

  function automatic bit ref_elig(input logic [31:0] x);
    int rd  = int'(x[11:7]);
    int rs1 = int'(x[19:15]);
    int rs2 = int'(x[24:20]);
    case (x[6:0])
      7'b0110011: return (x[31:25] == 7'h00 || x[31:25] == 7'h20) && in_lo(rd) && rs1 < 16 && rs2 < 16;
      7'b0010011: return in_lo(rd) && rs1 < 16;
      7'b0110111: return in_lo(rd);
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_remap(input logic [31:0] x);
    logic [31:0] y = x;
    int rd  = int'(x[11:7]);
    int rs1 = int'(x[19:15]);
    int rs2 = int'(x[24:20]);
    y[11:7] = 5'(rd + 16);
    if ((x[6:0] == 7'b0110011 || x[6:0] == 7'b0010011) && rs1 != 0) y[19:15] = 5'(rs1 + 16);
    if (x[6:0] == 7'b0110011 && rs2 != 0) y[24:20] = 5'(rs2 + 16);
    return y;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom();
    int k = $urandom_range(0, 9);
    r[11] = ($urandom_range(0, 3) == 0);
    r[19] = ($urandom_range(0, 3) == 0);
    r[24] = ($urandom_range(0, 3) == 0);
    if (k <= 3) begin
      r[6:0] = 7'b0110011;
      case ($urandom_range(0, 2))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        default: r[31:25] = 7'h01;
      endcase
    end else if (k <= 6) r[6:0] = 7'b0010011;
    else if (k <= 8) r[6:0] = 7'b0110111;
    else r[6:0] = 7'b0000011;
    return r;
  endfunction

  // driver: one cycle of stimulus, model prediction, ready check
  task automatic step(input logic v, input logic [31:0] ins, input logic ed, input logic st);
    logic er = 1'b0;
    @(negedge clk);
    inst_vld_i = v;
    inst_i     = ins;
    exec_dup_i = ed;
    stall_i    = st;
    #1;
    if (!st) begin
      if (mq.size() > 0 && (ed || mq.size() == 8)) begin
        m_inst = ref_remap(mq.pop_front());
        m_vld  = 1'b1;
        m_dup  = 1'b1;
      end else if (v) begin
        er = 1'b1;
        if (ref_elig(ins)) begin
          m_inst = ins;
          m_vld  = 1'b1;
          mq.push_back(ins);
        end else begin
          m_inst = NOP;
          m_vld  = 1'b0;
        end
        m_dup = 1'b0;
      end else begin
        m_inst = NOP;
        m_vld  = 1'b0;
        m_dup  = 1'b0;
      end
    end
    last_ready = er;
    check("inst_ready_o", {37'b0, inst_ready_o}, {37'b0, er});
    exp_q.push_back({m_inst, m_vld, m_dup, 4'(mq.size())});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_inst_o"}, {6'b0, inst_o}, {6'b0, NOP});
    check({tag, "_qed_vld_o"}, {37'b0, qed_vld_o}, 38'd0);
    check({tag, "_dup_o"}, {37'b0, dup_o}, 38'd0);
    check({tag, "_fifo_cnt_o"}, {34'b0, fifo_cnt_o}, 38'd0);
    check({tag, "_fifo_empty_o"}, {37'b0, fifo_empty_o}, 38'd1);
    check({tag, "_fifo_full_o"}, {37'b0, fifo_full_o}, 38'd0);
  endtask

  function automatic logic [31:0] addi_k(input int k);
    logic [31:0] x;
    x = {12'(k), 5'(k), 3'b000, 5'(k), 7'b0010011};
    return x;
  endfunction

  // scoreboard monitor
  initial begin
    logic [37:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("inst_o", {6'b0, inst_o}, {6'b0, e[37:6]});
        check("qed_vld_o", {37'b0, qed_vld_o}, {37'b0, e[5]});
        check("dup_o", {37'b0, dup_o}, {37'b0, e[4]});
        check("fifo_cnt_o", {34'b0, fifo_cnt_o}, {34'b0, e[3:0]});
        check("fifo_full_o", {37'b0, fifo_full_o}, {37'b0, (e[3:0] == 4'd8)});
        check("fifo_empty_o", {37'b0, fifo_empty_o}, {37'b0, (e[3:0] == 4'd0)});
      end
    end
  end

  initial begin
    logic [31:0] cur;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;

    // pass-through then duplicate
    step(1'b1, 32'h002081B3, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    // zero source stays zero in the duplicate
    step(1'b1, 32'h00700293, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    // filtering: mul, add x17, addi x0
    step(1'b1, 32'h022081B3, 1'b0, 1'b0);
    step(1'b1, 32'h002088B3, 1'b0, 1'b0);
    step(1'b1, 32'h00108013, 1'b0, 1'b0);

    // fill to full, then forced duplicate with input held
    for (int k = 1; k <= 8; k++) step(1'b1, addi_k(k), 1'b0, 1'b0);
    step(1'b1, addi_k(9), 1'b0, 1'b0);
    step(1'b1, addi_k(9), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
    // push/pop pairs across pointer wrap
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, addi_k(k + 10), 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end

    // stall with two queued
    step(1'b1, addi_k(3), 1'b0, 1'b0);
    step(1'b1, 32'h002081B3, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, addi_k(5), 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // reset mid-run with three queued
    for (int k = 1; k <= 3; k++) step(1'b1, addi_k(k), 1'b0, 1'b0);
    @(negedge clk);
    inst_vld_i = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_state("midreset");
    mq.delete();
    m_inst = NOP;
    m_vld  = 1'b0;
    m_dup  = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // randomized traffic; inst_i held until consumed
    cur = rand_inst();
    last_ready = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      step(v, cur, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      if (last_ready || !v) cur = rand_inst();
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 38'(exp_q.size()), 38'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
